board_display_scanner: RTL and testbench
========================================

// Module: board_display_scanner
// PURPOSE
//  Reader/display end of the connect-four board read port. Drives top_row_read/top_col_read,
//  consumes top_data_out, and refreshes a row-multiplexed 8x8 bicolour LED matrix through a
//  74HC595-style shift-register chain: 16 bits per row, then a latch pulse, then a row-on hold.
//  Overlays a blinking cursor (current player colour) in the top row and blinks the whole board after a win.
// PARAMETERS
//  CLK_DIV      1    sr_clk half-period in clk cycles (1..15)
//  HOLD_CYCLES  256  clk cycles each row stays lit (>=1)
//  BLINK_BIT    4    frame-counter bit used as blink phase (0..7)
// PORTS
//  clk                  in   1  system clock
//  rst_n                in   1  asynchronous active-low reset
//  top_data_out         in   2  board cell read data; 00 empty, 01 P1, 10 P2; valid 1 clk after address
//  port_current_col     in   3  cursor column
//  port_current_player  in   2  player to move (01/10)
//  winner               in   2  00 none, else winning player
//  top_row_read         out  3  board read row address (0 = bottom)
//  top_col_read         out  3  board read column address
//  sr_clk               out  1  shift clock; data sampled by the LED chain on the rising edge
//  sr_data              out  1  serial data, MSB first
//  sr_latch             out  1  one-clk storage-latch pulse
//  row_sel              out  8  one-hot active-high row enable; bit r lights row r
// BEHAVIOUR
//  - Reset: all outputs 0, state FETCH, row counter 0, frame counter 0, line buffer 0.
//  - States: FETCH -> SHIFT -> LATCH -> HOLD -> FETCH (next row).
//  - FETCH (9 clks): issue col 0..7 on consecutive clks at current row; data for col c captured
//    the clk after address c into line[2c] (P1/red) and line[2c+1] (P2/green). 11 is treated as empty.
//    After capture, a 16-bit line buffer is frozen for SHIFT.
//  - Overlay at end of FETCH, applied in priority order:
//    - winner!=00 and blink phase 0: line forced to 0.
//    - Otherwise, if row==7, winner==00, blink phase 1 and the cursor cell is empty:
//      line[2*cur_col + (player==10)] = 1.
//    - blink phase = frame_cnt[BLINK_BIT].
//  - SHIFT: 16 bits, line[15] first.
//    - Per bit: sr_data set with sr_clk low for CLK_DIV clks, then sr_clk high for CLK_DIV clks.
//    - sr_clk returns low after the last bit. Total 32*CLK_DIV clks.
//  - LATCH: sr_latch=1 for exactly 1 clk, sr_clk=0.
//  - HOLD: row_sel = 1<<row for HOLD_CYCLES clks.
//    - row_sel = 0 in every other state, so no ghosting while shifting.
//    - At exit: row = row+1 (7 wraps to 0). On the wrap, frame_cnt (8 bit) increments and wraps 255->0.
//  - Row period = 9 + 32*CLK_DIV + 1 + HOLD_CYCLES clks.
//  - top_row_read/top_col_read hold their last value outside FETCH.
//  - No handshake with the game controller. Reads that collide with a victory check may show
//    stale data for one row period. This is accepted.
//  - Inputs port_current_*/winner are sampled only at the overlay point, not synchronised further.
//  - Reset mid-operation: immediate return to reset values. A partial shift is abandoned with no latch pulse.
// TESTING
//  - Reset, then release with an empty board and blink phase 0:
//    - Addresses step row 0, col 0..7.
//    - 16 zero bits shifted, 1 latch pulse, then row_sel=8'h01 for 256 clks.
//  - Board cell (row0,col3)=P2, others empty -> row-0 shifted word 16'h0080.
//    - Stream is 0000000010000000; row_sel=01.
//  - Empty board, cursor col 0, player 01, frame_cnt[4]=1 -> row-7 word 16'h0001, other rows 0.
//    - With player 10 the row-7 word is 16'h0002.
//  - winner=01, full row 0 of P1:
//    - Row-0 word 16'h5555 in frames with bit4=1.
//    - 16'h0000 in frames with bit4=0; cursor never shown.
//  - CLK_DIV=2, HOLD_CYCLES=4 -> sr_clk high/low 2 clks each, row period 78 clks.
//    - Eight rows, then frame_cnt increments by 1.
//  - rst_n low mid-SHIFT -> sr_clk/sr_data/sr_latch/row_sel all 0 immediately.
//    - After release, scan restarts at row 0, col 0.

Source files
------------

// File: rtl/board_display_scanner.sv
// board_display_scanner
//   Reads the connect-four board one row at a time and refreshes a row-multiplexed 8x8 bicolour
//   LED matrix through a 74HC595-style shift-register chain. Each row is handled in four steps:
//   fetch 8 cells, shift 16 bits, pulse the latch, then hold the row lit. While the row is being
//   fetched and shifted, row_sel is 0, so the matrix does not ghost. A blinking cursor in the
//   current player's colour is overlaid on the top row, and the whole board blinks after a win.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   top_data_out         board cell data (00 empty, 01 P1, 10 P2), valid 1 clk after address
//   port_current_col     cursor column
//   port_current_player  player to move (01/10)
//   winner               00 none, else the winning player
//   top_row_read         board read row address (0 = bottom)
//   top_col_read         board read column address
//   sr_clk, sr_data      shift clock / serial data (MSB first, sampled on sr_clk rising)
//   sr_latch             one-clk storage latch pulse
//   row_sel              one-hot row enable, active high
module board_display_scanner #(
    parameter int unsigned CLK_DIV     = 1,
    parameter int unsigned HOLD_CYCLES = 256,
    parameter int unsigned BLINK_BIT   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] top_data_out,
    input  logic [2:0] port_current_col,
    input  logic [1:0] port_current_player,
    input  logic [1:0] winner,
    output logic [2:0] top_row_read,
    output logic [2:0] top_col_read,
    output logic       sr_clk,
    output logic       sr_data,
    output logic       sr_latch,
    output logic [7:0] row_sel
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {StFetch, StShift, StLatch, StHold} state_e;

    state_e           state_q, state_d;
    logic [3:0]       fetch_cnt_q, fetch_cnt_d;   // 0..8 within FETCH
    logic [2:0]       row_q, row_d;
    logic [2:0]       col_q, col_d;
    logic [15:0]      line_q, line_d;
    logic [3:0]       bit_q, bit_d;               // bit index, 0 = line[15]
    logic             phase_q, phase_d;           // 0 = sr_clk low half, 1 = high half
    logic [3:0]       div_q, div_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [7:0]       frame_q, frame_d;

    // Cell capture and overlay
    logic [2:0]  cap_col;
    logic [15:0] line_cap;
    logic [15:0] line_ovl;
    logic        blink;
    logic [3:0]  cur_idx;

    always_comb begin
        // Data for address col arrives one clk later, so cycle k captures column k-1.
        cap_col  = 3'(fetch_cnt_q - 4'd1);
        line_cap = line_q;
        line_cap[{cap_col, 1'b0}] = (top_data_out == 2'b01);
        line_cap[{cap_col, 1'b1}] = (top_data_out == 2'b10);

        blink   = frame_q[BLINK_BIT];
        cur_idx = {port_current_col, (port_current_player == 2'b10)};

        line_ovl = line_cap;
        if ((winner != 2'b00) && !blink) begin
            line_ovl = '0;
        end else if ((row_q == 3'd7) && (winner == 2'b00) && blink &&
                     !line_cap[{port_current_col, 1'b0}] &&
                     !line_cap[{port_current_col, 1'b1}]) begin
            line_ovl[cur_idx] = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        line_d      = line_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        div_d       = div_q;
        hold_d      = hold_q;
        frame_d     = frame_q;

        unique case (state_q)
            StFetch: begin
                if (fetch_cnt_q != 4'd0) begin
                    line_d = line_cap;
                end
                if (fetch_cnt_q == 4'd8) begin
                    line_d      = line_ovl;
                    fetch_cnt_d = 4'd0;
                    bit_d       = 4'd0;
                    phase_d     = 1'b0;
                    div_d       = 4'd0;
                    state_d     = StShift;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 4'd1;
                    // Column address stops at 7; it holds there for the final capture clk.
                    if (fetch_cnt_q < 4'd7) begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            StShift: begin
                if (div_q == 4'(CLK_DIV - 1)) begin
                    div_d = 4'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 4'd15) begin
                            state_d = StLatch;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 4'd1;
                end
            end
            StLatch: begin
                hold_d  = '0;
                state_d = StHold;
            end
            StHold: begin
                if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
                    state_d = StFetch;
                    row_d   = row_q + 3'd1;
                    col_d   = 3'd0;
                    if (row_q == 3'd7) begin
                        frame_d = frame_q + 8'd1;
                    end
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetch;
            fetch_cnt_q <= 4'd0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            line_q      <= 16'd0;
            bit_q       <= 4'd0;
            phase_q     <= 1'b0;
            div_q       <= 4'd0;
            hold_q      <= '0;
            frame_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            line_q      <= line_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            hold_q      <= hold_d;
            frame_q     <= frame_d;
        end
    end

    // Outputs are decoded from state only. An async reset therefore drops them at once.
    always_comb begin
        top_row_read = row_q;
        top_col_read = col_q;
        sr_clk       = (state_q == StShift) && phase_q;
        sr_data      = (state_q == StShift) ? line_q[~bit_q] : 1'b0;
        sr_latch     = (state_q == StLatch);
        row_sel      = (state_q == StHold) ? (8'd1 << row_q) : 8'd0;
    end

endmodule

// File: tb/tb_board_display_scanner.sv
module tb_board_display_scanner;

    localparam int BOUND = 200;

    logic       clk;
    logic       rst_n;
    logic [1:0] top_data_out;
    logic [2:0] port_current_col;
    logic [1:0] port_current_player;
    logic [1:0] winner;
    logic [2:0] top_row_read;
    logic [2:0] top_col_read;
    logic       sr_clk;
    logic       sr_data;
    logic       sr_latch;
    logic [7:0] row_sel;

    logic [1:0] board [8][8];
    int tot = 0;
    int bad = 0;
    int cyc = 0;

    board_display_scanner #(
        .CLK_DIV    (2),
        .HOLD_CYCLES(4),
        .BLINK_BIT  (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .top_data_out       (top_data_out),
        .port_current_col   (port_current_col),
        .port_current_player(port_current_player),
        .winner             (winner),
        .top_row_read       (top_row_read),
        .top_col_read       (top_col_read),
        .sr_clk             (sr_clk),
        .sr_data            (sr_data),
        .sr_latch           (sr_latch),
        .row_sel            (row_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Board memory with one clk read latency
    always @(posedge clk) top_data_out <= board[top_row_read][top_col_read];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Collect one row: the shifted word up to the latch, then the HOLD window.
    task automatic get_row(output logic [15:0] w, output logic [7:0] rs, output int hold_len,
                           output int hi_cyc, output int rises, output int latches,
                           output int lat_cyc);
        logic prev_clk;
        int n;
        w = '0; rs = '0; hold_len = 0; hi_cyc = 0; rises = 0; latches = 0; lat_cyc = 0;
        prev_clk = 1'b0;
        n = 0;
        while (latches == 0 && n < BOUND) begin
            @(negedge clk);
            n++;
            if (sr_clk && !prev_clk) begin
                w = {w[14:0], sr_data};
                rises++;
            end
            if (sr_clk) hi_cyc++;
            prev_clk = sr_clk;
            if (sr_latch) begin
                latches++;
                lat_cyc = cyc;
            end
        end
        while (row_sel == 8'd0 && n < BOUND) begin
            @(negedge clk);
            n++;
            if (sr_latch) latches++;
        end
        rs = row_sel;
        while (row_sel != 8'd0 && n < BOUND) begin
            hold_len++;
            @(negedge clk);
            n++;
        end
        check("row_timeout", 32'(n >= BOUND), 32'd0);
    endtask

    // Checks one frame. Rows 1..6 are expected to be blank.
    task automatic check_frame(input string tag, input logic [15:0] e0, input logic [15:0] e7,
                               input bit detail);
        logic [15:0] w;
        logic [7:0]  rs;
        int hl, hi, ri, la, lc, prev_lc;
        logic [15:0] exp;
        prev_lc = 0;
        for (int r = 0; r < 8; r++) begin
            get_row(w, rs, hl, hi, ri, la, lc);
            exp = (r == 0) ? e0 : ((r == 7) ? e7 : 16'h0000);
            check($sformatf("%s_r%0d_word", tag, r), 32'(w), 32'(exp));
            check($sformatf("%s_r%0d_rowsel", tag, r), 32'(rs), 32'(8'd1 << r));
            if (detail) begin
                check($sformatf("%s_r%0d_hold", tag, r), hl, 4);
                check($sformatf("%s_r%0d_sr_hi", tag, r), hi, 32);
                check($sformatf("%s_r%0d_rises", tag, r), ri, 16);
                check($sformatf("%s_r%0d_latch", tag, r), la, 1);
                if (r > 0) check($sformatf("%s_r%0d_period", tag, r), lc - prev_lc, 78);
            end
            prev_lc = lc;
        end
    endtask

    task automatic skip_frames(input int nf);
        logic [15:0] w;
        logic [7:0]  rs;
        int hl, hi, ri, la, lc;
        for (int i = 0; i < nf * 8; i++) get_row(w, rs, hl, hi, ri, la, lc);
    endtask

    initial begin
        logic [15:0] w;
        logic [7:0]  rs;
        int hl, hi, ri, la, lc, n;

        rst_n               = 1'b0;
        port_current_col    = 3'd0;
        port_current_player = 2'b01;
        winner              = 2'b00;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) board[r][c] = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_sr_clk", 32'(sr_clk), 0);
        check("rst_sr_data", 32'(sr_data), 0);
        check("rst_sr_latch", 32'(sr_latch), 0);
        check("rst_row_sel", 32'(row_sel), 0);
        check("rst_row_read", 32'(top_row_read), 0);
        check("rst_col_read", 32'(top_col_read), 0);

        rst_n = 1'b1;
        check("addr_c0", {29'd0, top_row_read} * 8 + 32'(top_col_read), 0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("addr_c%0d", k), {29'd0, top_row_read} * 8 + 32'(top_col_read), k);
        end

        // Frame 0: empty board, blink phase 0
        check_frame("f0", 16'h0000, 16'h0000, 1'b1);

        // Frame 1: P2 at row 0 col 3
        board[0][3] = 2'b10;
        check_frame("f1", 16'h0080, 16'h0000, 1'b0);

        // Frames 2..15 with no checks. Frame 16 is the first with frame_cnt[4]=1.
        skip_frames(14);
        board[0][3] = 2'b00;
        check_frame("f16", 16'h0000, 16'h0001, 1'b0);

        port_current_player = 2'b10;
        check_frame("f17", 16'h0000, 16'h0002, 1'b0);

        // Cursor over an occupied cell is not drawn.
        board[7][0] = 2'b01;
        check_frame("f18", 16'h0000, 16'h0001, 1'b0);

        port_current_col = 3'd7;
        check_frame("f19", 16'h0000, 16'h8001, 1'b0);

        // Win: board visible in blink phase 1, cursor suppressed, 11 reads as empty.
        winner = 2'b01;
        for (int c = 0; c < 8; c++) board[0][c] = 2'b01;
        board[1][2] = 2'b11;
        check_frame("f20", 16'h5555, 16'h0001, 1'b0);

        // Frame 32 has blink phase 0 while winner is set, so the display is blank.
        skip_frames(11);
        check_frame("f32", 16'h0000, 16'h0000, 1'b0);

        // Reset in the middle of shifting a 1 bit
        winner = 2'b00;
        n = 0;
        while (!(sr_clk && sr_data) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("midshift_found", 32'(n >= BOUND), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_sr_clk", 32'(sr_clk), 0);
        check("midrst_sr_data", 32'(sr_data), 0);
        check("midrst_sr_latch", 32'(sr_latch), 0);
        check("midrst_row_sel", 32'(row_sel), 0);
        repeat (2) @(negedge clk);
        check("midrst_latch_held", 32'(sr_latch), 0);
        rst_n = 1'b1;
        check("restart_addr0", {29'd0, top_row_read} * 8 + 32'(top_col_read), 0);
        @(negedge clk);
        check("restart_addr1", {29'd0, top_row_read} * 8 + 32'(top_col_read), 1);
        get_row(w, rs, hl, hi, ri, la, lc);
        check("restart_r0_word", 32'(w), 32'h5555);
        check("restart_r0_rowsel", 32'(rs), 32'h01);
        check("restart_r0_latch", la, 1);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
